time_keeper_encoder: RTL and testbench
======================================

TIME_KEEPER_ENCODER -- requirements
Module: time_keeper_encoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock cycles per second.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button level.
REQ-003 SHALL have port clk, input, 1, 50 MHz system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port btn_hour, input, 1, raw active-high hour-advance button, asynchronous to clk.
REQ-006 SHALL have port btn_min, input, 1, raw active-high minute-advance button, asynchronous to clk.
REQ-007 SHALL have ports seg_h10, seg_h1, seg_m10, seg_m1, output, 8 each, registered active-low segment patterns {dp,g,f,e,d,c,b,a} for hour tens, hour units, minute tens and minute units, consumed directly as the four digit inputs of the display multiplexer.
REQ-008 SHALL have port sec_tick, output, 1, registered one-cycle pulse per elapsed second.

Function
REQ-009 SHALL count a prescaler 0..CLK_HZ-1 and wrap; the cycle it wraps is the tick cycle; sec_tick is high the cycle after.
REQ-010 SHALL keep seconds 0..59, minutes 0..59, hours 0..23 as binary counters; tick increments seconds; 59->0 carries to minutes; minute 59->0 carries to hours; hour 23->0 wraps (23:59:59 + tick = 00:00:00).
REQ-011 SHALL pass each button through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any mismatch restarts the count.
REQ-012 SHALL generate one press pulse per debounced rising edge; held buttons produce no repeat; falling edges ignored.
REQ-013 SHALL on btn_min press set minutes to minutes+1 (59->0, no carry to hours) and clear seconds to 0.
REQ-014 SHALL on btn_hour press set hours to hours+1 (23->0); seconds and minutes unchanged.
REQ-015 SHALL apply both presses when they occur in the same cycle.
REQ-016 SHALL drop the tick entirely (no seconds advance, no carry) in any cycle where a press pulse is present; prescaler still wraps normally.
REQ-017 SHALL split hours and minutes into tens/units and encode each via 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp bit 1).
REQ-018 SHALL drive seg_h1 bit 7 (colon) to 0 while prescaler < CLK_HZ/2 and 1 otherwise; all other dp bits always 1.
REQ-019 SHALL register segment outputs: a counter change at edge N appears on outputs at edge N+1.

Reset
REQ-020 SHALL, while rst_n low, immediately force prescaler, seconds, minutes, hours to 0, synchronizers/debouncers to idle-low with counts 0, sec_tick 0, all seg outputs 8'hC0 (8'hFF for seg_h10 when HOUR_TENS_BLANK_EN defined).
REQ-021 SHALL on the first edge after rst_n rises present seg_h1 = 8'h40 (colon lit, prescaler 0).
REQ-022 SHALL, on reset asserted mid-debounce or mid-second, discard all partial progress; no press or tick is generated by the release.

Configuration
REQ-023 SHALL support macro HOUR_TENS_BLANK_EN: when defined, seg_h10 = 8'hFF (all segments off) whenever hours < 10; when undefined, seg_h10 always shows the tens digit (8'hC0 for hours < 10).

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-024 SHALL cover: rst_n low -> seg_h10/h1/m10/m1 = C0/C0/C0/C0, sec_tick 0; one edge after release -> seg_h1 = 40.
REQ-025 SHALL cover: 23 hour presses, 59 minute presses, then 60 ticks -> display 00:00 (C0,C0/40,C0,C0), intermediate 23:59 shows A4,B0,92,90.
REQ-026 SHALL cover: btn_min pulses of 1-3 cycles repeated 10 times -> minutes unchanged; then held 6 cycles -> exactly one increment, seg_m1 = F9.
REQ-027 SHALL cover: btn_min press pulse in the tick cycle at 00:00:59 -> 00:01:00 (not 00:02), sec_tick still pulses.
REQ-028 SHALL cover: rst_n dropped asynchronously between edges at 12:34 -> outputs C0 without waiting for clk; release -> counting restarts from 00:00:00.
REQ-029 SHALL cover: hours = 5 -> seg_h10 = FF with HOUR_TENS_BLANK_EN, C0 without; hours = 15 -> F9 in both builds.

Source files
------------

// File: rtl/time_keeper_encoder.sv
// ---------------------------------------------------------------------------
// time_keeper_encoder
//
// 24-hour HH:MM clock with a seconds prescaler, two debounced set buttons and
// registered active-low seven-segment patterns for a four-digit display.
//
// Parameters
//   CLK_HZ          : clk cycles per second (prescaler modulus)
//   DEBOUNCE_CYCLES : consecutive equal synchronized samples to accept a level
//
// Ports
//   clk      : system clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   btn_hour : raw hour-advance button (asynchronous to clk)
//   btn_min  : raw minute-advance button (asynchronous to clk)
//   seg_h10  : hour tens pattern   {dp,g,f,e,d,c,b,a}, active low
//   seg_h1   : hour units pattern; dp carries the blinking colon
//   seg_m10  : minute tens pattern
//   seg_m1   : minute units pattern
//   sec_tick : one-cycle pulse the cycle after each prescaler wrap
//
// Build option
//   HOUR_TENS_BLANK_EN : when defined, seg_h10 is blanked (8'hFF) for hours < 10
// ---------------------------------------------------------------------------
module time_keeper_encoder #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_hour,
    input  logic       btn_min,
    output logic [7:0] seg_h10,
    output logic [7:0] seg_h1,
    output logic [7:0] seg_m10,
    output logic [7:0] seg_m1,
    output logic       sec_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef HOUR_TENS_BLANK_EN
    localparam bit BLANK_TENS = 1'b1;
`else
    localparam bit BLANK_TENS = 1'b0;
`endif

    localparam logic [7:0] H10_RESET = BLANK_TENS ? 8'hFF : 8'hC0;

    // Digit to active-low {dp,g,f,e,d,c,b,a}; dp off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 8'hC0;
            4'd1:    seg_encode = 8'hF9;
            4'd2:    seg_encode = 8'hA4;
            4'd3:    seg_encode = 8'hB0;
            4'd4:    seg_encode = 8'h99;
            4'd5:    seg_encode = 8'h92;
            4'd6:    seg_encode = 8'h82;
            4'd7:    seg_encode = 8'hF8;
            4'd8:    seg_encode = 8'h80;
            4'd9:    seg_encode = 8'h90;
            default: seg_encode = 8'hFF;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = hour, index 1 = minute
    // ------------------------------------------------------------------
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    level_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [1:0]    accept;
    logic [1:0]    press;

    assign btn_raw = {btn_min, btn_hour};

    // The count only runs while the synchronized sample disagrees with the
    // accepted level, so reaching DEB_LAST on a disagreeing sample means
    // DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync2_q[i] != level_q[i]) && (deb_cnt_q[i] == DEB_LAST);
            press[i]  = accept[i] && sync2_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make the two synchronizer stages
            // shift rather than collapse into one flop.
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    level_q[i]   <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timekeeping
    // ------------------------------------------------------------------
    logic [PW-1:0] prescaler_q;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          sec_tick_q;
    logic          tick;

    assign tick = (prescaler_q == PRE_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;

        if (press[1]) begin
            min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            sec_d = 6'd0;
        end
        if (press[0]) begin
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end

        // A press in the tick cycle swallows that second completely.
        if (tick && (press == 2'b00)) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display encoding (from current state, so outputs lag counters by one)
    // ------------------------------------------------------------------
    logic [7:0] seg_h10_d, seg_h1_d, seg_m10_d, seg_m1_d;
    logic [7:0] seg_h10_q, seg_h1_q, seg_m10_q, seg_m1_q;

    always_comb begin
        seg_h10_d = seg_encode(4'(hour_q / 5'd10));
        seg_h1_d  = seg_encode(4'(hour_q % 5'd10));
        seg_m10_d = seg_encode(4'(min_q / 6'd10));
        seg_m1_d  = seg_encode(4'(min_q % 6'd10));

        if (BLANK_TENS && (hour_q < 5'd10)) begin
            seg_h10_d = 8'hFF;
        end
        // Colon lit (active low) during the first half of each second.
        if (prescaler_q < PRE_HALF) begin
            seg_h1_d[7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            sec_tick_q  <= 1'b0;
            seg_h10_q   <= H10_RESET;
            seg_h1_q    <= 8'hC0;
            seg_m10_q   <= 8'hC0;
            seg_m1_q    <= 8'hC0;
        end else begin
            prescaler_q <= tick ? '0 : prescaler_q + PW'(1);
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_tick_q  <= tick;
            seg_h10_q   <= seg_h10_d;
            seg_h1_q    <= seg_h1_d;
            seg_m10_q   <= seg_m10_d;
            seg_m1_q    <= seg_m1_d;
        end
    end

    assign seg_h10  = seg_h10_q;
    assign seg_h1   = seg_h1_q;
    assign seg_m10  = seg_m10_q;
    assign seg_m1   = seg_m1_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_keeper_encoder.sv
// ---------------------------------------------------------------------------
// tb_time_keeper_encoder
//
// Randomized and directed stimulus against a time-of-day reference model
// (seconds since midnight, sliding sample windows for the buttons).
// Build option HOUR_TENS_BLANK_EN changes the expected hour-tens pattern.
// ---------------------------------------------------------------------------
module tb_time_keeper_encoder;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;

`ifdef HOUR_TENS_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       btn_hour = 1'b0;
    logic       btn_min  = 1'b0;
    logic [7:0] seg_h10, seg_h1, seg_m10, seg_m1;
    logic       sec_tick;

    time_keeper_encoder #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_hour (btn_hour),
        .btn_min  (btn_min),
        .seg_h10  (seg_h10),
        .seg_h1   (seg_h1),
        .seg_m10  (seg_m10),
        .seg_m1   (seg_m1),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int         m_tod;                 // seconds since midnight
    int         m_pre;                 // prescaler phase
    bit         m_lvl  [2];            // accepted button level (0 hour, 1 min)
    bit         m_hist [2][DEB+2];     // raw samples, [0] = newest edge
    logic [7:0] e_h10, e_h1, e_m10, e_m1;
    logic       e_tick;

    task automatic model_reset();
        m_tod = 0;
        m_pre = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 1'b0;
            for (int k = 0; k < DEB + 2; k++) m_hist[b][k] = 1'b0;
        end
        e_h10  = BLANK ? 8'hFF : 8'hC0;
        e_h1   = 8'hC0;
        e_m10  = 8'hC0;
        e_m1   = 8'hC0;
        e_tick = 1'b0;
    endtask

    // One rising edge: display/tick reflect state before the edge, then the
    // time of day advances by presses or by the second tick.
    task automatic model_edge();
        bit pr [2];
        bit flip;
        bit tick;
        int h, mi, s;

        m_hist[0][0] = m_hist[0][0];
        for (int b = 0; b < 2; b++) begin
            for (int k = DEB + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        end
        m_hist[0][0] = btn_hour;
        m_hist[1][0] = btn_min;

        // Two synchronizer edges delay the raw sample; the level flips when
        // the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) if (m_hist[b][k] == m_lvl[b]) flip = 1'b0;
            pr[b] = flip && !m_lvl[b];
            if (flip) m_lvl[b] = !m_lvl[b];
        end

        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        e_h10  = (BLANK && h < 10) ? 8'hFF : pat[h / 10];
        e_h1   = pat[h % 10] & ((m_pre < CLK_HZ / 2) ? 8'h7F : 8'hFF);
        e_m10  = pat[mi / 10];
        e_m1   = pat[mi % 10];
        tick   = (m_pre == CLK_HZ - 1);
        e_tick = tick;
        m_pre  = (m_pre + 1) % CLK_HZ;

        if (pr[0] || pr[1]) begin
            if (pr[1]) begin
                mi = (mi + 1) % 60;
                s  = 0;
            end
            if (pr[0]) h = (h + 1) % 24;
            m_tod = h * 3600 + mi * 60 + s;
        end else if (tick) begin
            m_tod = (m_tod + 1) % 86400;
        end
    endtask

    task automatic compare_all();
        check("seg_h10", seg_h10, e_h10);
        check("seg_h1", seg_h1, e_h1);
        check("seg_m10", seg_m10, e_m10);
        check("seg_m1", seg_m1, e_m1);
        check("sec_tick", sec_tick, e_tick);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus helpers (all return on a falling edge)
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input bit is_min, input int hold);
        if (is_min) btn_min = 1'b1; else btn_hour = 1'b1;
        steps(hold);
        btn_min  = 1'b0;
        btn_hour = 1'b0;
        steps(DEB + 3);
    endtask

    // Drop reset between edges, check the immediate effect, release on a
    // falling edge and check the first post-reset colon pattern.
    task automatic apply_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        check({tag, " async h1"}, seg_h1, 8'hC0);
        @(negedge clk);
        compare_all();
        btn_hour = 1'b0;
        btn_min  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check({tag, " first h1"}, seg_h1, 8'h40);
    endtask

    task automatic wait_model(input int tod, input int pre, input int budget);
        int n = 0;
        while (!(m_tod == tod && (pre < 0 || m_pre == pre)) && n < budget) begin
            step();
            n++;
        end
        check("wait bound", (m_tod == tod && (pre < 0 || m_pre == pre)) ? 1 : 0, 1);
    endtask

    initial begin
        model_reset();

        // Reset state and first edge after release
        #1 rst_n = 1'b0;
        #1 compare_all();
        check("rst h10", seg_h10, BLANK ? 8'hFF : 8'hC0);
        check("rst m1", seg_m1, 8'hC0);
        check("rst tick", sec_tick, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("first h1", seg_h1, 8'h40);

        // Set 23:59 by buttons, then roll over midnight
        for (int i = 0; i < 23; i++) press(1'b0, 6);
        for (int i = 0; i < 59; i++) press(1'b1, 6);
        check("23:59 h10", seg_h10, 8'hA4);
        check("23:59 h1", seg_h1 | 8'h80, 8'hB0);
        check("23:59 m10", seg_m10, 8'h92);
        check("23:59 m1", seg_m1, 8'h90);
        wait_model(0, -1, 700);
        step();
        check("00:00 h10", seg_h10, BLANK ? 8'hFF : 8'hC0);
        check("00:00 h1", seg_h1 | 8'h80, 8'hC0);
        check("00:00 m10", seg_m10, 8'hC0);
        check("00:00 m1", seg_m1, 8'hC0);

        // Reset mid-debounce leaves no press behind
        btn_min = 1'b1;
        steps(4);
        apply_reset("mid-deb");
        steps(DEB + 3);
        check("mid-deb m1", seg_m1, 8'hC0);

        // Short glitches are rejected, a 6-cycle hold counts once
        for (int i = 0; i < 10; i++) begin
            btn_min = 1'b1;
            steps((i % 3) + 1);
            btn_min = 1'b0;
            steps(3);
        end
        check("glitch m1", seg_m1, 8'hC0);
        press(1'b1, 6);
        check("hold m1", seg_m1, 8'hF9);
        steps(10);
        check("held once m1", seg_m1, 8'hF9);

        // Press landing on the tick edge at 00:00:59
        apply_reset("tick-press");
        wait_model(59, 4, 700);
        btn_min = 1'b1;
        steps(6);
        check("press tick pulse", sec_tick, 1'b1);
        btn_min = 1'b0;
        step();
        check("press tick m10", seg_m10, 8'hC0);
        check("press tick m1", seg_m1, 8'hF9);
        steps(DEB + 3);

        // Asynchronous reset at 12:34, restart from midnight
        apply_reset("pre-1234");
        for (int i = 0; i < 12; i++) press(1'b0, 6);
        for (int i = 0; i < 34; i++) press(1'b1, 6);
        check("12:34 h10", seg_h10, 8'hF9);
        check("12:34 h1", seg_h1 | 8'h80, 8'hA4);
        check("12:34 m10", seg_m10, 8'hB0);
        check("12:34 m1", seg_m1, 8'h99);
        apply_reset("at-1234");
        check("restart m1", seg_m1, 8'hC0);
        steps(CLK_HZ + 2);

        // Hour tens blanking
        for (int i = 0; i < 5; i++) press(1'b0, 6);
        check("h05 h10", seg_h10, BLANK ? 8'hFF : 8'hC0);
        check("h05 h1", seg_h1 | 8'h80, 8'h92);
        for (int i = 0; i < 10; i++) press(1'b0, 6);
        check("h15 h10", seg_h10, 8'hF9);

        // Random button activity, including simultaneous presses
        for (int i = 0; i < 300; i++) begin
            btn_hour = 1'($urandom_range(0, 1));
            btn_min  = ($urandom_range(0, 3) == 0) ? btn_hour : 1'($urandom_range(0, 1));
            steps($urandom_range(1, 8));
        end
        btn_hour = 1'b0;
        btn_min  = 1'b0;
        steps(DEB + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
